reset_req: RTL and testbench
============================

Name: reset_req

Overview:
- Reset request source: watchdog timer plus software reset request.
- Drives the asynchronous `rst_in` input of the system reset generator with a clean, fixed-length, registered request pulse.
- Records why the last request fired (cause register) for readback after the system comes out of reset.
- Sits in the always-on clock domain, on power-on reset only; it is never reset by its own request.

Parameters:
- TOV, 1000000, watchdog timeout in clock cycles (min 1); counter width TOW = $clog2(TOV+1).
- PLS, 16, rst_req pulse length in cycles (min 1).
- HLD, 256, cooldown cycles after pulse, all inputs except rst_n ignored (min 1).
- WIN, 0, window threshold for RESET_REQ_WINDOW_EN (0 <= WIN < TOV); unused otherwise.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  watchdog enable, level.
- kick  input  1  watchdog service strobe, single-cycle.
- sw_rst  input  1  software reset request strobe, single-cycle.
- clr_cause  input  1  clears cause register.
- rst_req  output  1  reset request to reset generator, active-high, registered.
- busy  output  1  high in REQ or HOLD.
- cause  output  2  last request cause: 00 none, 01 timeout, 10 software, 11 window violation.
- cnt  output  TOW  current watchdog count (status).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, cnt=TOV, rst_req=0, busy=0, cause=00.
  - Pulse/hold counter = 0.
- States: IDLE, RUN, REQ, HOLD. All outputs registered.
- IDLE:
  - cnt held at TOV.
  - sw_rst -> REQ, cause=10.
  - Else en=1 -> RUN, cnt=TOV.
- RUN, priority in one cycle: sw_rst > en=0 > kick > expiry.
  - sw_rst -> REQ, cause=10.
  - en=0 -> IDLE, cnt=TOV.
  - kick -> cnt=TOV; a kick in the same cycle as cnt==0 prevents expiry.
  - Otherwise, if cnt==0 -> REQ, cause=01; else cnt decrements by 1. No wrap below 0.
  - Timeout latency: with no kicks, rst_req rises TOV+1 cycles after the RUN entry edge.
- REQ:
  - rst_req=1 for exactly PLS consecutive cycles, then -> HOLD.
  - en, kick, sw_rst ignored.
- HOLD:
  - rst_req=0 for exactly HLD cycles, then -> IDLE with cnt=TOV.
  - en, kick, sw_rst ignored; back-to-back requests are impossible.
- sw_rst latency: sw_rst sampled high at edge N -> rst_req high after edge N+1.
- busy = (state==REQ or HOLD).
- cause register:
  - Sticky; loaded on each REQ entry, overwriting any previous value.
  - clr_cause=1 sets cause=00, except in a cycle that loads a new cause; the new cause wins.
  - Not affected by en.
- Reset mid-operation: rst_n low in REQ forces rst_req=0 immediately (asynchronously).
- Width rule: all counter compares are at TOW bits; PLS/HLD counters are sized $clog2(max(PLS,HLD)+1).

Optional Feature:
- Macro: RESET_REQ_WINDOW_EN.
- Defined (windowed watchdog):
  - In RUN, a kick while cnt > WIN is a violation -> REQ, cause=11.
  - Priority is sw_rst > en=0 > violation.
  - A kick with cnt <= WIN reloads cnt=TOV normally.
- Undefined: WIN is ignored, every kick is legal, and cause=11 never occurs.

Test Plan (TOV=10, PLS=4, HLD=3, WIN=5 where used):
- Reset release, en=1 at cycle 0, never kick -> RUN at cycle 1; rst_req high cycles 12-15, low from 16; cause=01; busy high cycles 12-18; IDLE at cycle 19.
- Kick every 8 cycles in RUN for 200 cycles -> rst_req never asserts, cnt never below 2, cause stays 00.
- Kick exactly when cnt==0 -> cnt=10 next cycle, no request. sw_rst in that same cycle -> request with cause=10.
- sw_rst in IDLE with en=0 -> rst_req high for 4 cycles starting one cycle later. Second sw_rst during HOLD -> ignored, no second pulse.
- clr_cause after a timeout -> cause=00. clr_cause in the same cycle as an expiry -> cause=01. rst_n low during REQ -> rst_req=0 immediately, cause=00.
- RESET_REQ_WINDOW_EN defined: kick at cnt=8 -> request, cause=11. Kick at cnt=3 -> reload to 10, no request.

Source files
------------

// File: rtl/reset_req.sv
// reset_req: watchdog plus software reset request source for the system reset generator.
//
// Issues a fixed-length registered pulse on rst_req, followed by a cooldown during which
// every input except rst_n is ignored, and records the reason for the last request in a
// sticky cause register that survives the system reset it triggers.
//
// Optional build macro RESET_REQ_WINDOW_EN: when defined, a kick that arrives while the
// watchdog count is still above WIN is treated as a violation and fires a request with
// cause 2'b11. When undefined, WIN is ignored and every kick is legal.
//
// Request latency: a timeout or window violation raises rst_req on the same edge that
// enters REQ. A software request enters REQ on the sampling edge but holds rst_req low
// for one extra cycle, so rst_req rises one edge later.

module reset_req #(
  parameter int unsigned TOV = 1000000,
  parameter int unsigned PLS = 16,
  parameter int unsigned HLD = 256,
  parameter int unsigned WIN = 0,
  localparam int unsigned TOW = $clog2(TOV + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           kick,
  input  logic           sw_rst,
  input  logic           clr_cause,
  output logic           rst_req,
  output logic           busy,
  output logic [1:0]     cause,
  output logic [TOW-1:0] cnt
);

  // Pulse and hold share one down-counter sized for the longer of the two phases.
  localparam int unsigned PMAX = (PLS > HLD) ? PLS : HLD;
  localparam int unsigned PW   = $clog2(PMAX + 1);

  localparam logic [TOW-1:0] CntTov  = TOW'(TOV);
  localparam logic [PW-1:0]  PlsLast = PW'(PLS - 1);
  localparam logic [PW-1:0]  HldLast = PW'(HLD - 1);

`ifdef RESET_REQ_WINDOW_EN
  localparam logic [TOW-1:0] CntWin = TOW'(WIN);
`endif

  localparam logic [1:0] CauseNone = 2'b00;
  localparam logic [1:0] CauseTmo  = 2'b01;
  localparam logic [1:0] CauseSw   = 2'b10;
`ifdef RESET_REQ_WINDOW_EN
  localparam logic [1:0] CauseWin  = 2'b11;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StReq,
    StHold
  } state_e;

  state_e         state_q, state_d;
  logic [TOW-1:0] cnt_q, cnt_d;
  logic [PW-1:0]  pcnt_q, pcnt_d;
  logic           rst_req_q, rst_req_d;
  logic           busy_q, busy_d;
  logic [1:0]     cause_q, cause_d;
  // Set for the single REQ cycle that precedes a software-triggered pulse.
  logic           defer_q, defer_d;
  logic           load_cause;
  logic [1:0]     new_cause;

  // Next-state, counters and pulse control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pcnt_d     = pcnt_q;
    rst_req_d  = 1'b0;
    defer_d    = 1'b0;
    load_cause = 1'b0;
    new_cause  = CauseNone;

    unique case (state_q)
      StIdle: begin
        cnt_d = CntTov;
        if (sw_rst) begin
          state_d    = StReq;
          defer_d    = 1'b1;
          pcnt_d     = PlsLast;
          load_cause = 1'b1;
          new_cause  = CauseSw;
        end else if (en) begin
          state_d = StRun;
        end
      end

      StRun: begin
        if (sw_rst) begin
          state_d    = StReq;
          defer_d    = 1'b1;
          pcnt_d     = PlsLast;
          load_cause = 1'b1;
          new_cause  = CauseSw;
        end else if (!en) begin
          state_d = StIdle;
          cnt_d   = CntTov;
`ifdef RESET_REQ_WINDOW_EN
        end else if (kick && (cnt_q > CntWin)) begin
          // Kicked too early: the window is still closed.
          state_d    = StReq;
          rst_req_d  = 1'b1;
          pcnt_d     = PlsLast;
          load_cause = 1'b1;
          new_cause  = CauseWin;
`endif
        end else if (kick) begin
          // A kick at cnt == 0 lands here first and so prevents expiry.
          cnt_d = CntTov;
        end else if (cnt_q == '0) begin
          state_d    = StReq;
          rst_req_d  = 1'b1;
          pcnt_d     = PlsLast;
          load_cause = 1'b1;
          new_cause  = CauseTmo;
        end else begin
          cnt_d = cnt_q - TOW'(1);
        end
      end

      StReq: begin
        if (defer_q) begin
          rst_req_d = 1'b1;
        end else if (pcnt_q == '0) begin
          state_d = StHold;
          pcnt_d  = HldLast;
        end else begin
          rst_req_d = 1'b1;
          pcnt_d    = pcnt_q - PW'(1);
        end
      end

      StHold: begin
        if (pcnt_q == '0) begin
          state_d = StIdle;
          cnt_d   = CntTov;
        end else begin
          pcnt_d = pcnt_q - PW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = CntTov;
      end
    endcase
  end

  // Cause register: a newly loaded cause beats a clear; clears are ignored during cooldown.
  always_comb begin
    cause_d = cause_q;
    if (load_cause) begin
      cause_d = new_cause;
    end else if (clr_cause && (state_q != StHold)) begin
      cause_d = CauseNone;
    end
  end

  // Busy is registered from the next state so it lines up with the state register.
  always_comb begin
    busy_d = (state_d == StReq) || (state_d == StHold);
  end

  // State and output registers, cleared only by the power-on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= CntTov;
      pcnt_q    <= '0;
      rst_req_q <= 1'b0;
      busy_q    <= 1'b0;
      cause_q   <= CauseNone;
      defer_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      rst_req_q <= rst_req_d;
      busy_q    <= busy_d;
      cause_q   <= cause_d;
      defer_q   <= defer_d;
    end
  end

  assign rst_req = rst_req_q;
  assign busy    = busy_q;
  assign cause   = cause_q;
  assign cnt     = cnt_q;

endmodule

// File: tb/tb_reset_req.sv
// Bench for reset_req: directed stimulus, literal expectations at key points, and a
// time-window reference model compared against the DUT on every falling clock edge.

module tb_reset_req;

  localparam int unsigned TOV = 10;
  localparam int unsigned PLS = 4;
  localparam int unsigned HLD = 3;
  localparam int unsigned WIN = 5;
  localparam int unsigned TOW = $clog2(TOV + 1);
`ifdef RESET_REQ_WINDOW_EN
  localparam bit WinEn = 1'b1;
`else
  localparam bit WinEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           kick = 1'b0;
  logic           sw_rst = 1'b0;
  logic           clr_cause = 1'b0;
  logic           rst_req;
  logic           busy;
  logic [1:0]     cause;
  logic [TOW-1:0] cnt;

  always #5 clk = ~clk;

  reset_req #(
    .TOV(TOV),
    .PLS(PLS),
    .HLD(HLD),
    .WIN(WIN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .kick     (kick),
    .sw_rst   (sw_rst),
    .clr_cause(clr_cause),
    .rst_req  (rst_req),
    .busy     (busy),
    .cause    (cause),
    .cnt      (cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. A request is described by the edge m_ps at which the pulse starts:
  // rst_req is high after edges m_ps .. m_ps+PLS-1, the block is busy from the trigger
  // edge up to edge m_ps+PLS+HLD, where it returns to idle.
  int m_mode  = 0;  // 0 idle, 1 watching, 2 request in progress
  int m_cnt   = TOV;
  int m_cause = 0;
  int m_e     = 0;
  int m_ps    = -100;
  int exp_req = 0;
  int exp_busy = 0;

  task automatic model_step();
    int trig;
    int tc;
    trig = 0;
    tc   = 0;
    if (!rst_n) begin
      m_mode  = 0;
      m_cnt   = TOV;
      m_cause = 0;
      m_e     = 0;
      m_ps    = -100;
    end else begin
      m_e++;
      if (m_mode == 2) begin
        // Clears count until the pulse has finished; the cooldown ignores them.
        if (clr_cause && (m_e <= m_ps + PLS)) m_cause = 0;
        if (m_e == m_ps + PLS + HLD) begin
          m_mode = 0;
          m_cnt  = TOV;
        end
      end else begin
        if (sw_rst) begin
          trig = 1; tc = 2; m_ps = m_e + 1;
        end else if (m_mode == 0) begin
          if (en) begin
            m_mode = 1;
            m_cnt  = TOV;
          end
        end else if (!en) begin
          m_mode = 0;
          m_cnt  = TOV;
        end else if (kick && WinEn && (m_cnt > WIN)) begin
          trig = 1; tc = 3; m_ps = m_e;
        end else if (kick) begin
          m_cnt = TOV;
        end else if (m_cnt == 0) begin
          trig = 1; tc = 1; m_ps = m_e;
        end else begin
          m_cnt = m_cnt - 1;
        end
        if (trig != 0) begin
          m_mode  = 2;
          m_cause = tc;
        end else if (clr_cause) begin
          m_cause = 0;
        end
      end
    end
    exp_req  = ((m_mode == 2) && (m_e >= m_ps) && (m_e < m_ps + PLS)) ? 1 : 0;
    exp_busy = (m_mode == 2) ? 1 : 0;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // Cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_rst_req", int'(rst_req), exp_req);
      check("cyc_busy", int'(busy), exp_busy);
      check("cyc_cause", int'(cause), m_cause);
      check("cyc_cnt", int'(cnt), m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int min_cnt;
  int saw_req;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rst_req", int'(rst_req), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cause", int'(cause), 0);
    check("rst_cnt", int'(cnt), TOV);
    rst_n = 1'b1;

    // Timeout with no kicks: RUN at edge 1, pulse on edges 12-15, idle at edge 19
    en = 1'b1;
    tick();
    check("t1_run_cnt", int'(cnt), 10);
    repeat (10) tick();
    check("t1_cnt_zero", int'(cnt), 0);
    check("t1_no_req_yet", int'(rst_req), 0);
    tick();
    check("t1_req_rise", int'(rst_req), 1);
    check("t1_cause_tmo", int'(cause), 1);
    check("t1_busy", int'(busy), 1);
    repeat (3) tick();
    check("t1_req_last", int'(rst_req), 1);
    tick();
    check("t1_req_fall", int'(rst_req), 0);
    check("t1_busy_hold", int'(busy), 1);
    en = 1'b0;
    repeat (3) tick();
    check("t1_idle_busy", int'(busy), 0);
    check("t1_idle_cnt", int'(cnt), 10);

    // clr_cause after a timeout
    clr_cause = 1'b1;
    tick();
    clr_cause = 1'b0;
    check("t2_clr_cause", int'(cause), 0);

    // Periodic kicks every 8 cycles for 200 cycles
    en = 1'b1;
    min_cnt = TOV;
    saw_req = 0;
    for (int i = 0; i < 200; i++) begin
      kick = ((i % 8) == 7);
      tick();
      kick = 1'b0;
      if (rst_req) saw_req = 1;
      if (int'(cnt) < min_cnt) min_cnt = int'(cnt);
    end
    check("t3_no_req", saw_req, 0);
    check("t3_min_cnt_ge2", (min_cnt >= 2) ? 1 : 0, 1);
    check("t3_min_cnt", min_cnt, 3);
    check("t3_cause_none", int'(cause), 0);

    // Kick exactly at cnt == 0 prevents expiry
    repeat (10) tick();
    check("t4_cnt_zero", int'(cnt), 0);
    kick = 1'b1;
    tick();
    kick = 1'b0;
    check("t4_kick_reload", int'(cnt), 10);
    check("t4_kick_no_req", int'(rst_req), 0);
    // Kick plus sw_rst at cnt == 0: software request wins
    repeat (10) tick();
    kick = 1'b1;
    sw_rst = 1'b1;
    tick();
    kick = 1'b0;
    sw_rst = 1'b0;
    en = 1'b0;
    check("t4_sw_deferred", int'(rst_req), 0);
    check("t4_sw_busy", int'(busy), 1);
    check("t4_sw_cause", int'(cause), 2);
    tick();
    check("t4_sw_req", int'(rst_req), 1);
    repeat (7) tick();
    check("t4_idle", int'(busy), 0);

    // sw_rst in IDLE, then a second sw_rst during cooldown
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    check("t5_sw_deferred", int'(rst_req), 0);
    check("t5_cause", int'(cause), 2);
    tick();
    check("t5_req_rise", int'(rst_req), 1);
    repeat (3) tick();
    check("t5_req_last", int'(rst_req), 1);
    tick();
    check("t5_req_fall", int'(rst_req), 0);
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    repeat (2) tick();
    check("t5_idle", int'(busy), 0);
    repeat (4) tick();
    check("t5_no_second_req", int'(rst_req), 0);
    check("t5_no_second_busy", int'(busy), 0);

    // clr_cause on the expiry edge, then asynchronous reset in REQ
    en = 1'b1;
    tick();
    repeat (10) tick();
    clr_cause = 1'b1;
    tick();
    clr_cause = 1'b0;
    check("t6_clr_vs_expiry", int'(cause), 1);
    check("t6_req", int'(rst_req), 1);
    tick();
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    check("t6_async_req", int'(rst_req), 0);
    check("t6_async_cause", int'(cause), 0);
    check("t6_async_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Windowed kicks
    en = 1'b1;
    tick();
    repeat (2) tick();
    check("t7_cnt8", int'(cnt), 8);
    kick = 1'b1;
    tick();
    kick = 1'b0;
`ifdef RESET_REQ_WINDOW_EN
    check("t7_early_req", int'(rst_req), 1);
    check("t7_early_cause", int'(cause), 3);
    en = 1'b0;
    repeat (7) tick();
    check("t7_idle", int'(busy), 0);
    en = 1'b1;
    tick();
    repeat (7) tick();
    check("t7_cnt3", int'(cnt), 3);
    kick = 1'b1;
    tick();
    kick = 1'b0;
`endif
    check("t7_legal_reload", int'(cnt), 10);
    check("t7_legal_no_req", int'(rst_req), 0);
    en = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
